// File: rtl/pio_switch_poller.sv
// Periodically reads the switch PIO, debounces the value, latches per-bit change
// events and exposes DATA/EDGE/MASK/PERIOD plus a level interrupt to the CPU.
module pio_switch_poller #(
  parameter int DATA_W         = 8,
  parameter int PERIOD_W       = 24,
  parameter int DEFAULT_PERIOD = 50000,
  parameter int DEBOUNCE_N     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam logic [PERIOD_W-1:0] DEF_PERIOD = PERIOD_W'(DEFAULT_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE_PERIOD = PERIOD_W'(1);
  localparam logic [3:0]          DB_N       = 4'(DEBOUNCE_N);

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_EDGE   = 2'd1;
  localparam logic [1:0] A_MASK   = 2'd2;
  localparam logic [1:0] A_PERIOD = 2'd3;

  // One poll: IDLE (countdown) -> REQ -> CAPTURE -> UPDATE -> IDLE
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    CAPTURE = 2'd2,
    UPDATE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PERIOD_W-1:0] r_countdown;
  logic [PERIOD_W-1:0] r_period;
  logic [DATA_W-1:0]   r_sample;
  logic [DATA_W-1:0]   r_last_sample;
  logic [3:0]          r_stable_cnt;
  logic [DATA_W-1:0]   r_debounced;
  logic [DATA_W-1:0]   r_edge;
  logic [DATA_W-1:0]   r_mask;
  logic                r_m_read;
  logic [31:0]         r_s_readdata;
  logic                r_irq;

  logic                w_wr_edge;
  logic                w_wr_mask;
  logic                w_wr_period;
  logic [PERIOD_W-1:0] w_period_wdata;
  logic                w_same;
  logic [3:0]          w_stable_nxt;
  logic                w_accept;
  logic [DATA_W-1:0]   w_edge_set;
  logic [DATA_W-1:0]   w_edge_clr;
  logic [31:0]         w_rd_mux;
  logic                w_unused_bits;

  assign m_address  = 2'd0;
  assign m_read     = r_m_read;
  assign s_readdata = r_s_readdata;
  assign irq        = r_irq;

  assign w_unused_bits = ^{m_readdata[31:DATA_W], s_writedata[31:PERIOD_W]};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_countdown <= ONE_PERIOD) w_state_nxt = REQ;
      REQ:     w_state_nxt = CAPTURE;
      CAPTURE: w_state_nxt = UPDATE;
      UPDATE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------- CPU decode
  always_comb begin
    w_wr_edge      = s_write && (s_address == A_EDGE);
    w_wr_mask      = s_write && (s_address == A_MASK);
    w_wr_period    = s_write && (s_address == A_PERIOD);
    w_period_wdata = s_writedata[PERIOD_W-1:0];
    if (w_period_wdata == '0) w_period_wdata = ONE_PERIOD;
  end

  always_comb begin
    w_rd_mux = 32'd0;
    case (s_address)
      A_DATA:   w_rd_mux = 32'(r_debounced);
      A_EDGE:   w_rd_mux = 32'(r_edge);
      A_MASK:   w_rd_mux = 32'(r_mask);
      A_PERIOD: w_rd_mux = 32'(r_period);
      default:  w_rd_mux = 32'd0;
    endcase
  end

  // ------------------------------------------------------------ debounce
  always_comb begin
    w_same = (r_sample == r_last_sample);
    if (!w_same) begin
      w_stable_nxt = 4'd1;
    end else if (r_stable_cnt >= DB_N) begin
      w_stable_nxt = DB_N;
    end else begin
      w_stable_nxt = r_stable_cnt + 4'd1;
    end
    w_accept   = (r_state == UPDATE) && (w_stable_nxt == DB_N) && (r_sample != r_debounced);
    w_edge_set = w_accept ? (r_debounced ^ r_sample) : '0;
    w_edge_clr = w_wr_edge ? s_writedata[DATA_W-1:0] : '0;
  end

  // Poll timer: reloaded by UPDATE, or immediately by a PERIOD write while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_countdown <= DEF_PERIOD;
    end else if (r_state == UPDATE) begin
      r_countdown <= r_period;
    end else if (r_state == IDLE) begin
      if (w_wr_period) begin
        r_countdown <= w_period_wdata;
      end else if (r_countdown > ONE_PERIOD) begin
        r_countdown <= r_countdown - ONE_PERIOD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_read <= 1'b0;
    end else begin
      r_m_read <= (w_state_nxt == REQ);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sample      <= '0;
      r_last_sample <= '0;
      r_stable_cnt  <= 4'd0;
      r_debounced   <= '0;
    end else begin
      if (r_state == CAPTURE) begin
        r_sample <= m_readdata[DATA_W-1:0];
      end
      if (r_state == UPDATE) begin
        r_stable_cnt <= w_stable_nxt;
        if (!w_same) r_last_sample <= r_sample;
        if (w_accept) r_debounced <= r_sample;
      end
    end
  end

  // --------------------------------------------------------- registers
  // New events win over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge   <= '0;
      r_mask   <= '0;
      r_period <= DEF_PERIOD;
    end else begin
      r_edge <= (r_edge & ~w_edge_clr) | w_edge_set;
      if (w_wr_mask) r_mask <= s_writedata[DATA_W-1:0];
      if (w_wr_period) r_period <= w_period_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s_readdata <= 32'd0;
      r_irq        <= 1'b0;
    end else begin
      if (s_read) r_s_readdata <= w_rd_mux;
      r_irq <= |(r_edge & r_mask);
    end
  end

endmodule
